// File: rtl/nand_unit_arbiter.sv
// nand_unit_arbiter: round-robin arbiter and sequencer in front of one shared WIDTH-bit NAND unit.
// Optional macro NAND_XOR_MULTIPASS_EN adds XOR (op[2]=1) as a 4-pass NAND sequence on the same unit.
module nand_unit_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_nxt;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic             idle;
  logic             fire;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic [WIDTH-1:0] single;

  // Search upward from ptr, wrapping modulo NREQ; the first asserted request wins.
  always_comb begin : rr_search
    int idx;
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign fire = !rst && idle && grant_any;

  always_comb begin
    gnt = '0;
    if (fire) gnt[grant_id] = 1'b1;
  end

  assign sel_op  = op[3*grant_id +: 3];
  assign sel_a   = a[WIDTH*grant_id +: WIDTH];
  assign sel_b   = b[WIDTH*grant_id +: WIDTH];
  assign a_m     = sel_op[0] ? ~sel_a : sel_a;
  assign b_m     = sel_op[1] ? ~sel_b : sel_b;
  assign single  = ~(a_m & b_m);
  assign ptr_nxt = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;

`ifdef NAND_XOR_MULTIPASS_EN
  typedef enum logic [1:0] {IDLE, X1, X2, X3} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sel_xor;
  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] xb;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] t2;
  logic [WIDTH-1:0] t3;
  logic [ID_W-1:0]  xid;

  assign sel_xor = sel_op[2];
  assign idle    = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire && sel_xor) state_nxt = X1;
      X1:      state_nxt = X2;
      X2:      state_nxt = X3;
      X3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequence datapath registers carry no reset; state alone decides when their contents are consumed.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (fire) begin
        xa  <= sel_a;
        xb  <= sel_b;
        xid <= grant_id;
        n1  <= ~(sel_a & sel_b);
      end
      X1:      t2 <= ~(xa & n1);
      X2:      t3 <= ~(xb & n1);
      default: ;
    endcase
  end
`else
  logic unused_xor_bit;

  assign unused_xor_bit = sel_op[2];
  assign idle           = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (fire) ptr <= ptr_nxt;
`ifdef NAND_XOR_MULTIPASS_EN
      if (fire && !sel_xor) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grant_id;
        rsp_data  <= single;
      end else if (state == X3) begin
        rsp_valid <= 1'b1;
        rsp_id    <= xid;
        rsp_data  <= ~(t2 & t3);
      end
`else
      if (fire) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grant_id;
        rsp_data  <= single;
      end
`endif
    end
  end

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Self-checking bench for nand_unit_arbiter: directed steps followed by random traffic,
// compared against a transaction-level reference model (XOR expected as a plain a^b).
module tb_nand_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [2:0]            op_u [NREQ];
  logic [WIDTH-1:0]      a_u  [NREQ];
  logic [WIDTH-1:0]      b_u  [NREQ];
  logic [3*NREQ-1:0]     op_f;
  logic [WIDTH*NREQ-1:0] a_f;
  logic [WIDTH*NREQ-1:0] b_f;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign op_f[3*i +: 3]         = op_u[i];
    assign a_f[WIDTH*i +: WIDTH]  = a_u[i];
    assign b_f[WIDTH*i +: WIDTH]  = b_u[i];
  end

  nand_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op_f),
    .a         (a_f),
    .b         (b_f),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: transaction level, a countdown stands in for the multipass sequence.
  int             m_ptr   = 0;
  int             m_busy  = 0;
  bit             m_valid = 1'b0;
  int             m_id    = 0;
  logic [31:0]    m_data  = '0;
  int             m_xid   = 0;
  logic [31:0]    m_xdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_xor(input logic [2:0] o);
`ifdef NAND_XOR_MULTIPASS_EN
    return o[2];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [NREQ-1:0] model_gnt(output int w);
    w = 0;
    if (rst || m_busy > 0) return '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req[(m_ptr + k) % NREQ]) begin
        w = (m_ptr + k) % NREQ;
        return NREQ'(1) << w;
      end
    end
    return '0;
  endfunction

  task automatic model_edge(input logic [NREQ-1:0] eg, input int w);
    logic [31:0] am, bm;
    if (rst) begin
      m_ptr = 0; m_busy = 0; m_valid = 1'b0; m_id = 0; m_data = '0;
    end else begin
      m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1; m_id = m_xid; m_data = m_xdata;
        end
      end
      if (eg != '0) begin
        m_ptr = (w + 1) % NREQ;
        if (is_xor(op_u[w])) begin
          m_busy = 3; m_xid = w; m_xdata = a_u[w] ^ b_u[w];
        end else begin
          am = op_u[w][0] ? ~a_u[w] : a_u[w];
          bm = op_u[w][1] ? ~b_u[w] : b_u[w];
          m_valid = 1'b1; m_id = w; m_data = ~(am & bm);
        end
      end
    end
  endtask

  // One clock: check gnt mid-cycle, let the edge pass, check the response just after it.
  task automatic step(output logic [NREQ-1:0] g_obs, output logic [NREQ-1:0] g_exp);
    int w;
    #4;
    g_exp = model_gnt(w);
    g_obs = gnt;
    check("gnt", 64'(gnt), 64'(g_exp));
    @(posedge clk);
    model_edge(g_exp, w);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_id",    64'(rsp_id),    64'(m_id));
    check("rsp_data",  64'(rsp_data),  64'(m_data));
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    req[i] = 1'b1; op_u[i] = o; a_u[i] = av; b_u[i] = bv;
  endtask

  task automatic new_txn(input int i);
    set_req(i, 3'($urandom), $urandom, $urandom);
  endtask

  task automatic do_reset(input int n);
    logic [NREQ-1:0] go, ge;
    rst = 1'b1;
    for (int k = 0; k < n; k++) step(go, ge);
    rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] go, ge;
    logic [NREQ-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_u[i] = '0; a_u[i] = '0; b_u[i] = '0;
    end

    // Reset with every request raised.
    req = 4'hF;
    do_reset(2);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data",  64'(rsp_data),  64'd0);
    req = '0;

    // Plain NAND from requester 0.
    set_req(0, 3'b000, 32'hFFFF0000, 32'hFF00FF00);
    step(go, ge);
    check("nand_gnt",  64'(go), 64'h1);
    check("nand_data", 64'(rsp_data), 64'h00FFFFFF);
    req = '0;

    // Both inverts give OR, requester 2.
    set_req(2, 3'b011, 32'h0000000F, 32'h000000F0);
    step(go, ge);
    check("or_id",   64'(rsp_id),   64'd2);
    check("or_data", 64'(rsp_data), 64'h000000FF);
    req = '0;

    // Round-robin rotation with all requesters held high.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) new_txn(i);
    for (int i = 0; i < NREQ; i++) op_u[i][2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(go, ge);
      check("rr_gnt", 64'(go), 64'(exp_seq[k]));
      check("rr_id",  64'(rsp_id), 64'(k % NREQ));
    end
    req = '0;

    // XOR request from 0 while 1 waits.
    do_reset(1);
    set_req(0, 3'b100, 32'h0F0F0F0F, 32'h00FF00FF);
    set_req(1, 3'b000, 32'h12345678, 32'h9ABCDEF0);
    step(go, ge);
    check("xor_gnt_t", 64'(go), 64'h1);
    req[0] = 1'b0;
`ifdef NAND_XOR_MULTIPASS_EN
    for (int k = 1; k <= 3; k++) begin
      step(go, ge);
      check("xor_busy_gnt", 64'(go), 64'h0);
    end
    check("xor_valid", 64'(rsp_valid), 64'd1);
    check("xor_data",  64'(rsp_data),  64'h0FF00FF0);
    check("xor_id",    64'(rsp_id),    64'd0);
`else
    check("nomacro_data", 64'(rsp_data), 64'hFFF0FFF0);
`endif
    step(go, ge);
    check("after_xor_gnt", 64'(go), 64'h2);
    req = '0;
    step(go, ge);

    // Reset in the middle of an XOR sequence drops it.
    do_reset(1);
    set_req(0, 3'b100, $urandom, $urandom);
    step(go, ge);
    req = '0;
    step(go, ge);
    check("abort_valid_t1", 64'(rsp_valid), 64'd0);
    rst = 1'b1;
    step(go, ge);
    rst = 1'b0;
    check("abort_valid_t2", 64'(rsp_valid), 64'd0);
    for (int k = 3; k <= 6; k++) begin
      step(go, ge);
      check("abort_valid", 64'(rsp_valid), 64'd0);
    end
    set_req(0, 3'b000, $urandom, $urandom);
    set_req(1, 3'b001, $urandom, $urandom);
    step(go, ge);
    check("post_abort_gnt", 64'(go), 64'h1);
    req = '0;
    step(go, ge);

    // Random traffic; requesters hold operands until granted.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      step(go, ge);
      for (int i = 0; i < NREQ; i++) begin
        if (ge[i]) begin
          if ($urandom_range(0, 1) == 1) new_txn(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          new_txn(i);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
